// File: rtl/acl2_pkg.sv
// acl2_pkg -- shared ADXL362 opcodes, register addresses and sequencer state encoding (rev 1.0)
`default_nettype none

package acl2_pkg;

  localparam logic [7:0] CMD_WRITE_OP = 8'h0A;
  localparam logic [7:0] CMD_READ_OP  = 8'h0B;

  localparam logic [7:0] DEVID_AD  = 8'h00;
  localparam logic [7:0] XDATA_L   = 8'h0E;
  localparam logic [7:0] POWER_CTL = 8'h2D;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/acl2_reg_sequencer.sv
// acl2_reg_sequencer -- expands one ADXL362 register command into SPI FIFO byte traffic (rev 1.0)
// Header bytes (op, addr) are echoed back by the SPI engine and dropped; read data is streamed out.
`default_nettype none

module acl2_reg_sequencer
  import acl2_pkg::*;
#(
  parameter int LEN_MAX    = 8,
  parameter int GAP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  input  logic [3:0] cmd_len,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_last,
  output logic       done,
  output logic       spi_enable,
  output logic       tx_write,
  output logic [7:0] tx_data,
  input  logic       tx_full,
  output logic       rx_read,
  input  logic [7:0] rx_data,
  input  logic       rx_empty
);

  localparam int CW = $clog2(LEN_MAX + 3);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  seq_state_e    state_q, state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [CW-1:0] total_q, total_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          write_q, write_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic          rsp_last_q, rsp_last_d;
  logic          done_q, done_d;
  logic [CW-1:0] len_eff;

  always_comb begin
    if (cmd_len == 4'd0) begin
      len_eff = CW'(1);
    end else if (int'(cmd_len) > LEN_MAX) begin
      len_eff = CW'(LEN_MAX);
    end else begin
      len_eff = CW'(cmd_len);
    end
  end

  always_comb begin
    state_d     = state_q;
    tx_cnt_d    = tx_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    total_d     = total_q;
    gap_cnt_d   = gap_cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = 1'b0;
    done_d      = 1'b0;
    cmd_ready   = 1'b0;
    spi_enable  = 1'b0;
    tx_write    = 1'b0;
    tx_data     = 8'h00;
    rx_read     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          write_d  = cmd_write;
          addr_d   = cmd_addr;
          wdata_d  = cmd_wdata;
          total_d  = cmd_write ? CW'(3) : (CW'(2) + len_eff);
          tx_cnt_d = '0;
          rx_cnt_d = '0;
          state_d  = ST_XFER;
        end
      end

      ST_XFER: begin
        spi_enable = 1'b1;
        // tx_data follows tx_cnt, so a full FIFO naturally holds the pending byte
        if (tx_cnt_q == CW'(0)) begin
          tx_data = write_q ? CMD_WRITE_OP : CMD_READ_OP;
        end else if (tx_cnt_q == CW'(1)) begin
          tx_data = addr_q;
        end else begin
          tx_data = write_q ? wdata_q : 8'h00;
        end

        if ((tx_cnt_q < total_q) && !tx_full) begin
          tx_write = 1'b1;
          tx_cnt_d = tx_cnt_q + CW'(1);
        end

        if ((rx_cnt_q < total_q) && !rx_empty) begin
          rx_read  = 1'b1;
          rx_cnt_d = rx_cnt_q + CW'(1);
          if (!write_q && (rx_cnt_q >= CW'(2))) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = rx_data;
            rsp_last_d  = (rx_cnt_q == total_q - CW'(1));
          end
          if (rx_cnt_q == total_q - CW'(1)) begin
            done_d    = 1'b1;
            gap_cnt_d = '0;
            state_d   = ST_GAP;
          end
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tx_cnt_q    <= '0;
      rx_cnt_q    <= '0;
      total_q     <= '0;
      gap_cnt_q   <= '0;
      write_q     <= 1'b0;
      addr_q      <= 8'h00;
      wdata_q     <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      total_q     <= total_d;
      gap_cnt_q   <= gap_cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
      done_q      <= done_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;
  assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_acl2_reg_sequencer.sv
// tb_acl2_reg_sequencer -- directed bench with a loopback SPI FIFO model for acl2_reg_sequencer
`default_nettype none
`timescale 1ns/1ps

module tb_acl2_reg_sequencer;
  import acl2_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic [3:0] cmd_len = 4'd0;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_last;
  logic       done;
  logic       spi_enable;
  logic       tx_write;
  logic [7:0] tx_data;
  logic       tx_full = 1'b0;
  logic       rx_read;
  logic [7:0] rx_data_r;
  logic       rx_empty_r;

  acl2_reg_sequencer #(.LEN_MAX(8), .GAP_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_len    (cmd_len),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_last   (rsp_last),
    .done       (done),
    .spi_enable (spi_enable),
    .tx_write   (tx_write),
    .tx_data    (tx_data),
    .tx_full    (tx_full),
    .rx_read    (rx_read),
    .rx_data    (rx_data_r),
    .rx_empty   (rx_empty_r)
  );

  always #5 clk = ~clk;

  // SPI engine model: every pushed TX byte returns one RX byte from rsrc on the next cycle
  logic [7:0] txlog[$];
  logic [7:0] rxq[$];
  logic [7:0] rsrc[256];
  logic [8:0] rsplog[$];
  logic [7:0] rpat[8];
  int done_cnt = 0, viol_txfull = 0, viol_rxempty = 0, viol_en = 0, done_mis = 0;
  logic cur_read = 1'b0;
  int n_assert = 0, n_fail = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      txlog.delete();
      rxq.delete();
      rx_data_r  <= 8'h00;
      rx_empty_r <= 1'b1;
    end else begin
      if (rx_read && rxq.size() > 0) void'(rxq.pop_front());
      if (tx_write) begin
        rxq.push_back(rsrc[txlog.size() % 256]);
        txlog.push_back(tx_data);
      end
      rx_data_r  <= (rxq.size() > 0) ? rxq[0] : 8'h00;
      rx_empty_r <= (rxq.size() == 0);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_write && tx_full) viol_txfull++;
      if (rx_read && rx_empty_r) viol_rxempty++;
      if ((tx_write || rx_read) && !spi_enable) viol_en++;
      if (rsp_valid) rsplog.push_back({rsp_last, rsp_data});
      if (done) begin
        done_cnt++;
        if (cur_read && !(rsp_valid && rsp_last)) done_mis++;
      end
      if (rsp_last && !done) done_mis++;
    end
  end

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                        input logic [3:0] len, input int stall_at, input string tag);
    int tb0, rb0, d0, leff, n, i, gap, bad;
    logic [7:0] op, exp;
    tb0  = txlog.size();
    rb0  = rsplog.size();
    d0   = done_cnt;
    leff = (len == 0) ? 1 : ((len > 8) ? 8 : int'(len));
    n    = wr ? 3 : 2 + leff;
    op   = wr ? 8'h0A : 8'h0B;
    for (int k = 0; k < n; k++)
      rsrc[(tb0 + k) % 256] = (k < 2) ? 8'(8'hC0 + k) : rpat[k-2];
    cur_read = !wr;

    chk({tag, "_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_len   = len;
    step;
    cmd_valid = 1'b0;
    chk({tag, "_first_tx"}, {spi_enable, tx_write, tx_data}, {1'b1, 1'b1, op});

    i = 0;
    while (done_cnt == d0 && i < 200) begin
      if (stall_at > 0 && i == stall_at) tx_full = 1'b1;
      if (stall_at > 0 && i == stall_at + 2)
        chk({tag, "_stall_hold"}, {tx_write, tx_data}, {1'b0, addr});
      if (stall_at > 0 && i == stall_at + 5) tx_full = 1'b0;
      step;
      i++;
    end
    tx_full = 1'b0;
    chk({tag, "_done_seen"}, (done_cnt != d0), 1);
    chk({tag, "_en_low"}, spi_enable, 0);

    gap = 0;
    while (!cmd_ready && gap < 20) begin
      chk({tag, "_gap_en"}, spi_enable, 0);
      gap++;
      step;
    end
    chk({tag, "_gap_len"}, gap, 4);
    chk({tag, "_ndone"}, done_cnt - d0, 1);
    chk({tag, "_ntx"}, txlog.size() - tb0, n);
    bad = 0;
    for (int k = 0; k < n; k++) begin
      exp = (k == 0) ? op : (k == 1) ? addr : (wr ? wdata : 8'h00);
      if (txlog[tb0 + k] !== exp) bad++;
    end
    chk({tag, "_tx_bytes"}, bad, 0);
    chk({tag, "_nrsp"}, rsplog.size() - rb0, wr ? 0 : leff);
    if (!wr) begin
      bad = 0;
      for (int k = 0; k < leff; k++)
        if (rsplog[rb0 + k] !== {(k == leff - 1), rpat[k]}) bad++;
      chk({tag, "_rsp_bytes"}, bad, 0);
    end
  endtask

  initial begin
    int tb0;
    for (int k = 0; k < 256; k++) rsrc[k] = 8'hEE;
    for (int k = 0; k < 8; k++) rpat[k] = 8'h00;
    rst = 1'b1;
    step;
    step;
    rst = 1'b0;
    step;

    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_spi_enable", spi_enable, 0);
    chk("rst_tx_write", tx_write, 0);
    chk("rst_rx_read", rx_read, 0);
    chk("rst_rsp_flags", {rsp_valid, rsp_last, done}, 3'b000);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_rsp_data", rsp_data, 8'h00);

    do_cmd(1'b1, POWER_CTL, 8'h02, 4'd0, 0, "wr_powerctl");

    rpat[0] = 8'hAD;
    do_cmd(1'b0, DEVID_AD, 8'h00, 4'd1, 0, "rd_devid");
    chk("rd_devid_data", rsplog[rsplog.size()-1], {1'b1, 8'hAD});

    for (int k = 0; k < 8; k++) rpat[k] = 8'((k + 1) * 17);
    do_cmd(1'b0, XDATA_L, 8'h00, 4'd6, 0, "rd_burst6");
    chk("rd_burst6_last", rsplog[rsplog.size()-1], {1'b1, 8'h66});
    chk("rd_burst6_first", rsplog[rsplog.size()-6], {1'b0, 8'h11});

    for (int k = 0; k < 8; k++) rpat[k] = 8'(8'hA0 + k);
    do_cmd(1'b0, XDATA_L, 8'h00, 4'd6, 1, "rd_stall");

    rpat[0] = 8'h5A;
    do_cmd(1'b0, 8'h10, 8'h00, 4'd0, 0, "rd_len0");

    for (int k = 0; k < 8; k++) rpat[k] = 8'(8'h31 + k);
    do_cmd(1'b0, XDATA_L, 8'h00, 4'd15, 0, "rd_len15");

    // abort a read burst with reset part-way through
    tb0 = txlog.size();
    for (int k = 0; k < 10; k++) rsrc[(tb0 + k) % 256] = 8'h99;
    cur_read  = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = XDATA_L;
    cmd_len   = 4'd8;
    step;
    cmd_valid = 1'b0;
    step;
    step;
    chk("mid_pre_en", spi_enable, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_en", spi_enable, 0);
    chk("mid_rst_tx", tx_write, 0);
    chk("mid_rst_rx", rx_read, 0);
    chk("mid_rst_rsp", {rsp_valid, done}, 2'b00);
    step;
    step;
    rst = 1'b0;
    step;
    chk("post_rst_ready", cmd_ready, 1);

    do_cmd(1'b1, POWER_CTL, 8'h00, 4'd0, 0, "wr_after_rst");

    chk("no_tx_when_full", viol_txfull, 0);
    chk("no_rx_when_empty", viol_rxempty, 0);
    chk("traffic_only_enabled", viol_en, 0);
    chk("done_with_last", done_mis, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, limit 200000 ns reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
